plaintext_block_packer: RTL and testbench
=========================================

Name: plaintext_block_packer

Overview:
Upstream feeder for the 64-bit encryption datapath. It accepts a byte stream over a valid/ready handshake and packs each group of 8 bytes into one 64-bit plaintext block. The final block of each message is padded PKCS#7-style. Each completed block is presented on a held valid/ready output that drives the encryptor's 64-bit plaintext input.

Parameters:
- PAD_ENABLE, default 1: 1 selects PKCS#7 padding; 0 zero-fills a partial final block and never emits an extra pad block.
- BLOCK_BYTES, default 8: bytes per block. Fixed at 8; any other value is a synthesis-time error.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- s_data, input, 8: input byte.
- s_valid, input, 1: s_data is valid.
- s_last, input, 1: s_data is the last byte of the message.
- s_ready, output, 1: the packer accepts a byte this cycle.
- m_block, output, 64: packed plaintext block; the first byte of the block sits in [63:56].
- m_valid, output, 1: m_block is valid.
- m_last, output, 1: this block is the final block of its message.
- m_pad_len, output, 4: number of pad bytes in m_block (0..8).
- m_ready, input, 1: the downstream stage takes the block.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=FILL, byte_cnt=0, pend_pad=0.
  - m_block=0, m_valid=0, m_last=0, m_pad_len=0.
  - s_ready=0 while rst is high.
  - Reset mid-message discards the partial block and any held block without handshake.
- Byte transfer occurs when s_valid && s_ready. Block transfer occurs when m_valid && m_ready.
- s_ready = (state==FILL) && !rst. It is a combinational decode of state only and never depends on s_valid.
- State FILL:
  - An accepted byte is written to m_block[63-8*byte_cnt -: 8], then byte_cnt increments.
  - Accept with byte_cnt==7 and s_last=0: go to HOLD; m_last=0, m_pad_len=0.
  - Accept with byte_cnt==7 and s_last=1: go to HOLD; m_last=!PAD_ENABLE, m_pad_len=0, pend_pad=PAD_ENABLE.
  - Accept with byte_cnt<7 and s_last=1: go to PAD.
  - No accept: hold state and data.
- State PAD (exactly 1 cycle, s_ready=0):
  - Let n = 8 - byte_cnt (1..7).
  - Fill the remaining low bytes with n when PAD_ENABLE=1, or with 0x00 when PAD_ENABLE=0.
  - m_pad_len = n if PAD_ENABLE=1, else 0. m_last=1.
  - Go to HOLD.
- State HOLD:
  - m_valid=1. m_block, m_last and m_pad_len stay stable until transfer.
  - Transfer with pend_pad=1: m_block=64'h0808_0808_0808_0808, m_pad_len=8, m_last=1, pend_pad=0; remain in HOLD.
  - Transfer with pend_pad=0: go to FILL, byte_cnt=0, m_valid=0 on the next cycle.
  - m_valid is deasserted only after a transfer.
- m_valid is a registered output equal to (state==HOLD).
- Latency:
  - Full block: 8th byte accepted at cycle N gives m_valid=1 at N+1.
  - Partial final block: last byte accepted at N gives m_valid=1 at N+2.
- Throughput: no byte is accepted while in PAD or HOLD (no overlap), so a full block needs at least 9 cycles.
- s_last with s_valid=0 is ignored.
- An empty message cannot be expressed; every message carries at least one byte.
- byte_cnt is 3 bits. Its wrap from 7 to 0 happens only on the FILL to HOLD transition.

Decomposition:
- Shared package:
  - state typedef {FILL, PAD, HOLD}.
  - BLOCK_BYTES=8.
  - FULL_PAD_BLOCK = 64'h0808080808080808.
  - Byte-lane index helper.
- One natural sub-module: pkcs_pad_fill. It is combinational and maps (partial block, byte_cnt, PAD_ENABLE) to (padded block, pad_len). This logic is reused later by the decrypt-side unpad checker.

Test Plan:
1. 8-byte message 00..07 with s_last on byte 07, PAD_ENABLE=1, m_ready=1 -> block 0x0001020304050607 (m_last=0, pad 0), then 0x0808080808080808 (m_last=1, pad 8).
2. 3-byte message AA BB CC, PAD_ENABLE=1 -> m_block=0xAABBCC0505050505, m_pad_len=5, m_last=1, m_valid 2 cycles after the last accept.
3. Same 3 bytes with PAD_ENABLE=0 -> 0xAABBCC0000000000, pad 0, m_last=1, no extra block.
4. 16 bytes 10..1F with m_ready held low 5 cycles on block 1 -> m_block=0x1011121314151617 stable and s_ready=0 throughout; block 2 = 0x18191A1B1C1D1E1F follows, then the full-pad block.
5. rst asserted after 5 bytes of a message, then a fresh 1-byte message 0x42 -> no stale block emitted; output 0x4207070707070707, pad 7, m_last=1.
6. s_valid toggled randomly with one byte per accept, 7-byte message 01..07 -> 0x0102030405060701, pad 1; the byte count matches the number of handshakes only.

Source files
------------

// File: rtl/plaintext_block_packer_pkg.sv
// Shared types and constants for the plaintext block packer and its pad-fill helper.
package plaintext_block_packer_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int          BLOCK_BYTES    = 8;
    localparam logic [63:0] FULL_PAD_BLOCK = 64'h0808_0808_0808_0808;

    // Bit position of the LSB of byte lane idx; lane 0 is the first byte, in [63:56].
    function automatic logic [5:0] lane_lsb(input logic [2:0] idx);
        return 6'd56 - {idx, 3'b000};
    endfunction

endpackage

// File: rtl/plaintext_block_packer_pad_fill.sv
// Combinational PKCS#7 (or zero) fill of the unused low byte lanes of a partial block.
module pkcs_pad_fill
    import plaintext_block_packer_pkg::*;
#(
    parameter int PAD_ENABLE = 1
) (
    input  logic [63:0] blk_in,
    input  logic [2:0]  byte_cnt,
    output logic [63:0] blk_out,
    output logic [3:0]  pad_len
);

    logic [3:0] n;
    logic [7:0] fill;

    always_comb begin
        n       = 4'd8 - {1'b0, byte_cnt};
        fill    = (PAD_ENABLE != 0) ? {4'b0000, n} : 8'h00;
        pad_len = (PAD_ENABLE != 0) ? n : 4'd0;
        blk_out = blk_in;
        // Lanes at or beyond byte_cnt hold no message data.
        for (int i = 0; i < 8; i++) begin
            if (3'(i) >= byte_cnt) begin
                blk_out[lane_lsb(3'(i)) +: 8] = fill;
            end
        end
    end

endmodule

// File: rtl/plaintext_block_packer.sv
// Packs a byte stream into 64-bit plaintext blocks with PKCS#7 final-block padding.
module plaintext_block_packer
    import plaintext_block_packer_pkg::*;
#(
    parameter int PAD_ENABLE  = 1,
    parameter int BLOCK_BYTES = plaintext_block_packer_pkg::BLOCK_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [63:0] m_block,
    output logic        m_valid,
    output logic        m_last,
    output logic [3:0]  m_pad_len,
    input  logic        m_ready
);

    if (BLOCK_BYTES != 8) begin : g_bad_block_bytes
        $error("plaintext_block_packer supports only BLOCK_BYTES == 8");
    end

    state_t      state_q, state_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic        pend_pad_q, pend_pad_d;
    logic [63:0] m_block_q, m_block_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic [3:0]  m_pad_len_q, m_pad_len_d;

    logic [63:0] pad_blk;
    logic [3:0]  pad_len;
    logic        byte_acc;
    logic        blk_acc;

    pkcs_pad_fill #(
        .PAD_ENABLE (PAD_ENABLE)
    ) u_pad_fill (
        .blk_in   (m_block_q),
        .byte_cnt (byte_cnt_q),
        .blk_out  (pad_blk),
        .pad_len  (pad_len)
    );

    assign s_ready   = (state_q == FILL) && !rst;
    assign byte_acc  = s_valid && s_ready;
    assign blk_acc   = m_valid_q && m_ready;
    assign m_block   = m_block_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_pad_len = m_pad_len_q;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        pend_pad_d  = pend_pad_q;
        m_block_d   = m_block_q;
        m_last_d    = m_last_q;
        m_pad_len_d = m_pad_len_q;

        case (state_q)
            FILL: begin
                if (byte_acc) begin
                    m_block_d[lane_lsb(byte_cnt_q) +: 8] = s_data;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7) begin
                        state_d     = HOLD;
                        m_pad_len_d = 4'd0;
                        m_last_d    = s_last && (PAD_ENABLE == 0);
                        pend_pad_d  = s_last && (PAD_ENABLE != 0);
                    end else if (s_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                m_block_d   = pad_blk;
                m_pad_len_d = pad_len;
                m_last_d    = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (blk_acc) begin
                    // A message that ended on a block boundary still owes a full pad block.
                    if (pend_pad_q) begin
                        m_block_d   = FULL_PAD_BLOCK;
                        m_pad_len_d = 4'd8;
                        m_last_d    = 1'b1;
                        pend_pad_d  = 1'b0;
                    end else begin
                        state_d    = FILL;
                        byte_cnt_d = 3'd0;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        m_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            byte_cnt_q  <= 3'd0;
            pend_pad_q  <= 1'b0;
            m_block_q   <= 64'd0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_pad_len_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            pend_pad_q  <= pend_pad_d;
            m_block_q   <= m_block_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_pad_len_q <= m_pad_len_d;
        end
    end

endmodule

// File: tb/tb_plaintext_block_packer.sv
// Scoreboard bench: unit 0 pads PKCS#7, unit 1 zero-fills; expectations come from a message-level model.
module tb_plaintext_block_packer;

    typedef struct {
        logic [63:0] blk;
        logic        last;
        logic [3:0]  pad;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data    [2];
    logic        s_valid   [2];
    logic        s_last    [2];
    logic        s_ready   [2];
    logic [63:0] m_block   [2];
    logic        m_valid   [2];
    logic        m_last    [2];
    logic [3:0]  m_pad_len [2];
    logic        m_ready   [2];

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hold_low [2];
    bit rand_rdy = 0;

    int          cnt     [2];
    int          exp_cyc [2];
    bit          part    [2];
    logic        prev_v  [2];
    logic        prev_r  [2];
    logic [63:0] prev_blk[2];
    logic        prev_lst[2];
    logic [3:0]  prev_pad[2];

    plaintext_block_packer #(.PAD_ENABLE(1)) u_pad (
        .clk(clk), .rst(rst),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]), .s_ready(s_ready[0]),
        .m_block(m_block[0]), .m_valid(m_valid[0]), .m_last(m_last[0]),
        .m_pad_len(m_pad_len[0]), .m_ready(m_ready[0])
    );

    plaintext_block_packer #(.PAD_ENABLE(0)) u_zero (
        .clk(clk), .rst(rst),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]), .s_ready(s_ready[1]),
        .m_block(m_block[1]), .m_valid(m_valid[1]), .m_last(m_last[1]),
        .m_pad_len(m_pad_len[1]), .m_ready(m_ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int u, input exp_t e);
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Message-level reference: split into 8-byte chunks, pad the short tail, add a pad block if needed.
    task automatic model(input int u, input logic [7:0] msg[$]);
        int   len;
        bit   pe;
        exp_t e;
        len = msg.size();
        pe  = (u == 0);
        for (int i = 0; i < len; i += 8) begin
            int          k;
            logic [63:0] b;
            logic [7:0]  v;
            k = (len - i < 8) ? len - i : 8;
            b = 64'd0;
            for (int j = 0; j < 8; j++) begin
                if (j < k) v = msg[i + j];
                else       v = pe ? 8'(8 - k) : 8'h00;
                b = {b[55:0], v};
            end
            e.blk  = b;
            e.pad  = (k < 8 && pe) ? 4'(8 - k) : 4'd0;
            e.last = (k < 8) || ((i + 8 == len) && !pe);
            push_exp(u, e);
        end
        if ((len % 8 == 0) && pe) begin
            e.blk  = 64'h0808_0808_0808_0808;
            e.pad  = 4'd8;
            e.last = 1'b1;
            push_exp(u, e);
        end
    endtask

    task automatic send_msg(input int u, input logic [7:0] msg[$], input bit rv, input bit partial);
        bit hs;
        if (!partial) model(u, msg);
        for (int i = 0; i < msg.size(); i++) begin
            if (rv) begin
                while ($urandom % 2 == 1) begin
                    s_valid[u] = 1'b0;
                    s_last[u]  = 1'($urandom % 2);
                    s_data[u]  = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            s_valid[u] = 1'b1;
            s_data[u]  = msg[i];
            s_last[u]  = !partial && (i == msg.size() - 1);
            hs = 1'b0;
            for (int t = 0; t < 300 && !hs; t++) begin
                @(negedge clk);
                hs = s_ready[u];
                @(posedge clk);
                #1;
            end
            if (!hs) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout u%0d: byte %0d not accepted, required within 300 cycles", u, i);
            end
            s_valid[u] = 1'b0;
            s_last[u]  = 1'b0;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && (q0.size() != 0 || q1.size() != 0); t++) @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d/%0d blocks outstanding, required 0", q0.size(), q1.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic mon(input int u);
        exp_t e;
        bit   empty;
        if (exp_cyc[u] == cyc) chk($sformatf("u%0d_latency_valid", u), m_valid[u], 1);
        if (part[u] && exp_cyc[u] - 1 == cyc) chk($sformatf("u%0d_pad_cycle_valid", u), m_valid[u], 0);
        if (prev_v[u] && !prev_r[u]) begin
            chk($sformatf("u%0d_hold_valid", u), m_valid[u], 1);
            chk($sformatf("u%0d_hold_block", u), m_block[u], prev_blk[u]);
            chk($sformatf("u%0d_hold_last", u), m_last[u], prev_lst[u]);
            chk($sformatf("u%0d_hold_pad", u), m_pad_len[u], prev_pad[u]);
        end
        if (m_valid[u]) chk($sformatf("u%0d_s_ready_in_hold", u), s_ready[u], 0);
        if (m_valid[u] && m_ready[u]) begin
            empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL u%0d_unexpected_block: got %0h, expected no block", u, m_block[u]);
            end else begin
                if (u == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("u%0d_block", u), m_block[u], e.blk);
                chk($sformatf("u%0d_last", u), m_last[u], e.last);
                chk($sformatf("u%0d_pad_len", u), m_pad_len[u], e.pad);
            end
        end
        if (s_valid[u] && s_ready[u]) begin
            cnt[u]++;
            if (cnt[u] == 8 || s_last[u]) begin
                part[u]    = (cnt[u] != 8);
                exp_cyc[u] = cyc + (part[u] ? 2 : 1);
                cnt[u]     = 0;
            end
        end
        prev_v[u]   = m_valid[u];
        prev_r[u]   = m_ready[u];
        prev_blk[u] = m_block[u];
        prev_lst[u] = m_last[u];
        prev_pad[u] = m_pad_len[u];
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            cnt[u] = 0; exp_cyc[u] = -10; part[u] = 0; prev_v[u] = 0; prev_r[u] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int u = 0; u < 2; u++) begin
                    chk($sformatf("u%0d_s_ready_in_reset", u), s_ready[u], 0);
                    cnt[u] = 0; exp_cyc[u] = -10; part[u] = 0; prev_v[u] = 0; prev_r[u] = 0;
                end
            end else begin
                for (int u = 0; u < 2; u++) mon(u);
            end
        end
    end

    initial begin
        hold_low[0] = 0;
        hold_low[1] = 0;
        m_ready[0]  = 1'b1;
        m_ready[1]  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                if (hold_low[u] > 0) begin
                    m_ready[u] = 1'b0;
                    if (m_valid[u]) hold_low[u]--;
                end else begin
                    m_ready[u] = rand_rdy ? 1'($urandom % 2) : 1'b1;
                end
            end
        end
    end

    task automatic check_idle_after_reset(input int u);
        chk($sformatf("u%0d_rst_m_valid", u), m_valid[u], 0);
        chk($sformatf("u%0d_rst_m_block", u), m_block[u], 0);
        chk($sformatf("u%0d_rst_m_last", u), m_last[u], 0);
        chk($sformatf("u%0d_rst_m_pad_len", u), m_pad_len[u], 0);
        chk($sformatf("u%0d_rst_s_ready", u), s_ready[u], 1);
    endtask

    initial begin
        logic [7:0] msg[$];
        int         u;
        int         len;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0; s_last[i] = 1'b0; s_data[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_after_reset(0);
        check_idle_after_reset(1);
        @(posedge clk);
        #1;

        // Exact multiple of 8: data block then full pad block.
        msg = {};
        for (int i = 0; i < 8; i++) msg.push_back(8'(i));
        send_msg(0, msg, 0, 0);
        drain();

        // Short message, padded and zero-filled.
        msg = {8'hAA, 8'hBB, 8'hCC};
        send_msg(0, msg, 0, 0);
        drain();
        send_msg(1, msg, 0, 0);
        drain();

        // Zero-fill unit with a full block: no extra pad block.
        msg = {};
        for (int i = 0; i < 8; i++) msg.push_back(8'(8'h30 + i));
        send_msg(1, msg, 0, 0);
        drain();

        // Backpressure on the first of two blocks.
        hold_low[0] = 5;
        msg = {};
        for (int i = 0; i < 16; i++) msg.push_back(8'(8'h10 + i));
        send_msg(0, msg, 0, 0);
        drain();

        // Reset mid-message discards the partial block.
        msg = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_msg(0, msg, 0, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_after_reset(0);
        @(posedge clk);
        #1;
        msg = {8'h42};
        send_msg(0, msg, 0, 0);
        drain();

        // Gapped valid with s_last noise while idle.
        msg = {};
        for (int i = 1; i <= 7; i++) msg.push_back(8'(i));
        send_msg(0, msg, 1, 0);
        drain();
        send_msg(1, msg, 1, 0);
        drain();

        // Randomized messages with random backpressure.
        rand_rdy = 1;
        for (int n = 0; n < 40; n++) begin
            u   = $urandom % 2;
            len = $urandom_range(1, 20);
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            send_msg(u, msg, 1, 0);
            drain();
        end
        rand_rdy = 0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
